// File: rtl/floor_pkg.sv
// Shared definitions for the floor step counter.
//   DIR_UP / DIR_DOWN          : encoding of the up_down input
//   DEFAULT_NUM_FLOORS         : default floor count
//   DEFAULT_TICKS_PER_FLOOR    : default enabled cycles per one-floor step
//   floor_index_width()        : width of a floor index, never below 1 bit
package floor_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int DEFAULT_NUM_FLOORS      = 8;
   localparam int DEFAULT_TICKS_PER_FLOOR = 4;

   function automatic int floor_index_width(input int num_floors);
      return (num_floors > 2) ? $clog2(num_floors) : 1;
   endfunction

endpackage

// File: rtl/step_prescaler.sv
// Tick prescaler for the floor step counter.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, clears the tick count
//   run     : count this cycle; when low the tick count clears
//   restart : treat the current tick as 0 this cycle (direction change)
//   tc      : terminal count, high in the cycle that completes TICKS runs
module step_prescaler
   import floor_pkg::*;
#(
   parameter int TICKS = DEFAULT_TICKS_PER_FLOOR
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic restart,
   output logic tc
);

   localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [TW-1:0] LAST = TW'(TICKS - 1);

   logic [TW-1:0] tick;
   logic [TW-1:0] tick_eff;

   // A restart counts the current cycle as the first tick of a fresh run,
   // so any partial progress in the old direction is discarded.
   assign tick_eff = restart ? '0 : tick;
   assign tc       = run && (tick_eff == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         tick <= '0;
      end else if (!run || tc) begin
         tick <= '0;
      end else begin
         tick <= tick_eff + TW'(1);
      end
   end

endmodule

// File: rtl/floor_step_counter.sv
// Floor position counter that steps one floor after TICKS_PER_FLOOR
// consecutive enabled cycles, saturating at the bottom and top floors.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   enable     : motion request
//   up_down    : 1 = up, 0 = down
//   load       : synchronous preset of count (beats enable)
//   load_value : preset floor index, clamped to the top floor
//   count      : current floor index (registered)
//   step       : one-cycle pulse when count shows a stepped value
//   limit_hit  : registered, enable pushing against a boundary
//   at_top     : count == NUM_FLOORS-1
//   at_bottom  : count == 0
module floor_step_counter
   import floor_pkg::*;
#(
   parameter int  NUM_FLOORS      = DEFAULT_NUM_FLOORS,
   parameter int  TICKS_PER_FLOOR = DEFAULT_TICKS_PER_FLOOR,
   localparam int W               = floor_index_width(NUM_FLOORS)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         up_down,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] count,
   output logic         step,
   output logic         limit_hit,
   output logic         at_top,
   output logic         at_bottom
);

   localparam logic [W-1:0] TOP = W'(NUM_FLOORS - 1);

   function automatic logic [W-1:0] clamp_floor(input logic [W-1:0] v);
      if (int'(v) > NUM_FLOORS - 1) begin
         return TOP;
      end
      return v;
   endfunction

   logic dir_q;
   logic legal;
   logic run;
   logic restart;
   logic tc;

   assign at_top    = (count == TOP);
   assign at_bottom = (count == '0);

   assign legal   = (up_down == DIR_UP) ? !at_top : !at_bottom;
   assign run     = !load && enable && legal;
   assign restart = (up_down != dir_q);

   step_prescaler #(
      .TICKS (TICKS_PER_FLOOR)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .restart (restart),
      .tc      (tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         step      <= 1'b0;
         limit_hit <= 1'b0;
         dir_q     <= DIR_UP;
      end else begin
         dir_q     <= up_down;
         step      <= 1'b0;
         limit_hit <= 1'b0;
         if (load) begin
            count <= clamp_floor(load_value);
         end else if (enable) begin
            if (!legal) begin
               limit_hit <= 1'b1;
            end else if (tc) begin
               count <= (up_down == DIR_UP) ? count + W'(1) : count - W'(1);
               step  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/floor_step_counter.md
FLOOR_STEP_COUNTER -- requirements
Module: floor_step_counter

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of floors; legal range 2..256.
REQ-002 Parameter TICKS_PER_FLOOR, default 4, consecutive enabled cycles per one-floor step; legal range >= 1.
REQ-003 Derived constant W = max(1, ceil(log2(NUM_FLOORS))), the width of the floor index.
REQ-004 One clock; reset is synchronous and active-high; the clock port is clk and the reset port is reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  motion request; count advances only while this is high.
REQ-008 up_down  input  1  1 = count up, 0 = count down.
REQ-009 load  input  1  synchronous preset of count.
REQ-010 load_value  input  W  preset floor index.
REQ-011 count  output  W  current floor index, registered.
REQ-012 step  output  1  one-cycle pulse in the first cycle count shows a new value from a step.
REQ-013 limit_hit  output  1  registered; high while enable pushes against a boundary.
REQ-014 at_top  output  1  decode of count == NUM_FLOORS-1.
REQ-015 at_bottom  output  1  decode of count == 0.

Function
REQ-016 Priority per cycle SHALL be: reset, then load, then enable, then hold.
REQ-017 On load, count SHALL take min(load_value, NUM_FLOORS-1), the tick counter SHALL clear, and step and limit_hit SHALL be 0 next cycle.
REQ-018 An internal tick counter (0..TICKS_PER_FLOOR-1) SHALL increment each cycle with enable=1 and movement legal.
REQ-019 When tick == TICKS_PER_FLOOR-1 and movement is legal, count SHALL change by +1 (up) or -1 (down), tick SHALL return to 0, and step SHALL be 1 in the following cycle only.
REQ-020 Movement SHALL be legal unless (up_down=1 and count=NUM_FLOORS-1) or (up_down=0 and count=0); no wrap-around.
REQ-021 With enable=1 and movement illegal, count SHALL hold, tick SHALL stay 0, and limit_hit SHALL be 1 next cycle.
REQ-022 limit_hit SHALL be 0 in any cycle following one without that condition.
REQ-023 With enable=0, count SHALL hold and tick SHALL clear to 0.
REQ-024 When up_down differs from its value registered in the previous cycle while enable=1, tick SHALL restart at 0 in that cycle, with no partial credit kept.
REQ-025 With TICKS_PER_FLOOR=1, count SHALL step on every enabled legal cycle.
REQ-026 at_top and at_bottom SHALL be pure decodes of registered count, with no extra latency.

Reset
REQ-027 On reset, count SHALL be 0, tick 0, step 0, limit_hit 0, and the registered direction 1; hence at_bottom=1 and at_top=0.
REQ-028 Reset asserted mid-travel SHALL discard the partial tick count; the first step after release SHALL need a full TICKS_PER_FLOOR enabled cycles.

Structure
REQ-029 Shared package floor_pkg SHALL hold DIR_UP=1, DIR_DOWN=0, and the default NUM_FLOORS and TICKS_PER_FLOOR.
REQ-030 The tick counter SHALL be a sub-module step_prescaler with parameter TICKS, inputs clk, reset, run, restart, and a terminal-count output.
REQ-031 All outputs except at_top and at_bottom SHALL be driven directly from flops.

Verification (NUM_FLOORS=8, TICKS_PER_FLOOR=4)
REQ-032 Reset, then enable=1, up_down=1 for 12 cycles -> count 1,2,3 at cycles 5,9,13 after release; step pulses once per change.
REQ-033 load=1, load_value=6, then enable=1 up for 10 cycles -> count=7 after 4 cycles; at_top=1; limit_hit=1 from then on; count never wraps to 0.
REQ-034 count=3, up for 2 cycles, up_down=0 for 4 cycles -> count=2; no step on the up side.
REQ-035 load_value=12 -> count=7 and step=0; load and enable both high in one cycle -> load wins, tick=0.
REQ-036 Enable up for 3 cycles, reset 1 cycle, then enable 4 cycles -> count 0 until the 4th post-reset cycle, then 1.
REQ-037 At count=0, down with enable for 5 cycles -> count=0, limit_hit=1, step never asserted.
